// File: rtl/sigmul_pkg.sv
// ---------------------------------------------------------------------------
// sigmul_pkg
// Shared widths and format constants for the significand multiplier.
//
// Contents:
//   NSIG_HALF / NSIG_SINGLE / NSIG_DOUBLE : stored-fraction widths per format
//   pw_of(nsig) : product width, 2*nsig+2 (two (nsig+1)-bit significands)
//   lo_of(nsig) : low-half width of the carry-propagate split, nsig+1
//   hi_of(nsig) : high-half width, pw_of(nsig) - lo_of(nsig)
// ---------------------------------------------------------------------------
package sigmul_pkg;

  localparam int NSIG_HALF   = 10;
  localparam int NSIG_SINGLE = 23;
  localparam int NSIG_DOUBLE = 52;

  function automatic int pw_of(input int nsig);
    return 2 * nsig + 2;
  endfunction

  // The split sits at the significand width, so the low half of the adder
  // is as wide as one multiplier operand.
  function automatic int lo_of(input int nsig);
    return nsig + 1;
  endfunction

  function automatic int hi_of(input int nsig);
    return pw_of(nsig) - lo_of(nsig);
  endfunction

endpackage

// File: rtl/sigmul_cpa_pipe_rca.sv
// ---------------------------------------------------------------------------
// rca_slice
// W-bit carry-propagate adder slice: {cout_o, sum_o} = a_i + b_i + cin_i.
// Used for both halves of the pipelined final adder.
//
// Ports:
//   a_i, b_i : W-bit addends
//   cin_i    : carry in
//   sum_o    : W-bit sum
//   cout_o   : carry out of bit W-1
// ---------------------------------------------------------------------------
module rca_slice #(
  parameter int W = 11
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] fullSum;

  // One extra bit of headroom captures the carry out of the slice.
  assign fullSum = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign sum_o   = fullSum[W-1:0];
  assign cout_o  = fullSum[W];

endmodule

// File: rtl/sigmul_cpa_pipe.sv
// ---------------------------------------------------------------------------
// sigmul_cpa_pipe
// Final carry-propagate stage of the significand multiplier. Resolves the
// redundant sum/carry pair from the 3:2 compression tree into a binary
// product through a two-stage adder split at the significand boundary.
// Stage A adds the low halves and registers the carry; stage B adds the
// high halves with that carry. Valid/ready handshakes on both sides, one
// op per cycle, two cycles of latency without back-pressure.
//
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : s_in/c_in/in_tag valid
//   in_ready   : stage accepts this cycle
//   s_in, c_in : PW-bit compressed sum/carry vectors, bit 0 aligned
//   in_tag     : sideband tag, carried through unmodified
//   out_valid  : prod/msb/out_tag valid
//   out_ready  : downstream accepts
//   prod       : (s_in + c_in) mod 2^PW
//   msb        : prod[PW-1], normalize-shift hint
//   out_tag    : tag of the op presented on prod
// ---------------------------------------------------------------------------
module sigmul_cpa_pipe
  import sigmul_pkg::*;
#(
  parameter int NSIG = NSIG_HALF,
  parameter int TAGW = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [pw_of(NSIG)-1:0]  s_in,
  input  logic [pw_of(NSIG)-1:0]  c_in,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [pw_of(NSIG)-1:0]  prod,
  output logic                    msb,
  output logic [TAGW-1:0]         out_tag
);

  localparam int PW = pw_of(NSIG);
  localparam int LO = lo_of(NSIG);
  localparam int HI = hi_of(NSIG);

  // Stage A state
  logic            validA_q, validA_d;
  logic [LO-1:0]   loSumA_q, loSumA_d;
  logic            carryA_q, carryA_d;
  logic [HI-1:0]   hiSA_q, hiSA_d;
  logic [HI-1:0]   hiCA_q, hiCA_d;
  logic [TAGW-1:0] tagA_q, tagA_d;

  // Stage B state (drives the outputs directly)
  logic            validB_q, validB_d;
  logic [PW-1:0]   prodB_q, prodB_d;
  logic            msbB_q, msbB_d;
  logic [TAGW-1:0] tagB_q, tagB_d;

  // Handshake and adder nets
  logic            advA, advB, accept;
  logic [LO-1:0]   loSum;
  logic            loCarry;
  logic [HI-1:0]   hiSum;
  logic            hiCarryUnused;

  // Each stage may move whenever the stage after it has room; in_ready is
  // a function of pipeline state only, never of in_valid.
  assign advB     = !validB_q | out_ready;
  assign advA     = !validA_q | advB;
  assign in_ready = advA;
  assign accept   = in_valid & advA;

  // Low half is summed straight off the inputs; only the result and its
  // carry are kept, so stage B never sees the raw low bits.
  rca_slice #(.W(LO)) u_rcaLo (
    .a_i    (s_in[LO-1:0]),
    .b_i    (c_in[LO-1:0]),
    .cin_i  (1'b0),
    .sum_o  (loSum),
    .cout_o (loCarry)
  );

  // The carry out of the top bit is the mod-2^PW wrap and is dropped.
  rca_slice #(.W(HI)) u_rcaHi (
    .a_i    (hiSA_q),
    .b_i    (hiCA_q),
    .cin_i  (carryA_q),
    .sum_o  (hiSum),
    .cout_o (hiCarryUnused)
  );

  // Next-state for both stages. Valid bits follow the advance rules;
  // data registers only load when a real op moves into them, so idle
  // (possibly X) input buses never reach the pipeline.
  always_comb begin
    validA_d = validA_q;
    loSumA_d = loSumA_q;
    carryA_d = carryA_q;
    hiSA_d   = hiSA_q;
    hiCA_d   = hiCA_q;
    tagA_d   = tagA_q;
    validB_d = validB_q;
    prodB_d  = prodB_q;
    msbB_d   = msbB_q;
    tagB_d   = tagB_q;

    if (advA) begin
      validA_d = in_valid;
    end
    if (accept) begin
      loSumA_d = loSum;
      carryA_d = loCarry;
      hiSA_d   = s_in[PW-1:LO];
      hiCA_d   = c_in[PW-1:LO];
      tagA_d   = in_tag;
    end

    if (advB) begin
      validB_d = validA_q;
    end
    if (advB && validA_q) begin
      prodB_d = {hiSum, loSumA_q};
      msbB_d  = hiSum[HI-1];
      tagB_d  = tagA_q;
    end
  end

  // Pipeline registers. Reset flushes everything in flight and clears the
  // output data so downstream sees a clean zero product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validA_q <= 1'b0;
      loSumA_q <= '0;
      carryA_q <= 1'b0;
      hiSA_q   <= '0;
      hiCA_q   <= '0;
      tagA_q   <= '0;
      validB_q <= 1'b0;
      prodB_q  <= '0;
      msbB_q   <= 1'b0;
      tagB_q   <= '0;
    end else begin
      validA_q <= validA_d;
      loSumA_q <= loSumA_d;
      carryA_q <= carryA_d;
      hiSA_q   <= hiSA_d;
      hiCA_q   <= hiCA_d;
      tagA_q   <= tagA_d;
      validB_q <= validB_d;
      prodB_q  <= prodB_d;
      msbB_q   <= msbB_d;
      tagB_q   <= tagB_d;
    end
  end

  assign out_valid = validB_q;
  assign prod      = prodB_q;
  assign msb       = msbB_q;
  assign out_tag   = tagB_q;

endmodule

// File: tb/tb_sigmul_cpa_pipe.sv
// ---------------------------------------------------------------------------
// tb_sigmul_cpa_pipe
// Directed bench for the pipelined carry-propagate adder at NSIG = 10
// (22-bit product). Every task starts and ends on a falling clock edge;
// inputs change and outputs are sampled there, half a cycle away from the
// rising edge the DUT uses.
// ---------------------------------------------------------------------------
module tb_sigmul_cpa_pipe;

  localparam int NSIG = 10;
  localparam int TAGW = 4;
  localparam int PW   = 2 * NSIG + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   s_in;
  logic [PW-1:0]   c_in;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   prod;
  logic            msb;
  logic [TAGW-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  sigmul_cpa_pipe #(
    .NSIG (NSIG),
    .TAGW (TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .c_in      (c_in),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .msb       (msb),
    .out_tag   (out_tag)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence of tasks
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  // Hold reset across two edges, check the cleared outputs, then release
  // and expect the input side to open on the very next cycle.
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    c_in      = '0;
    in_tag    = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (prod !== '0) begin
      errors++;
      $display("[TB] FAIL reset_prod got %h want 000000", prod);
    end
    checks++;
    if (msb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_msb got %b want 0", msb);
    end
    checks++;
    if (out_tag !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out_tag got %h want 0", out_tag);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  // Single isolated ops: latency of exactly two cycles, correct sum and
  // msb, and nothing extra afterwards. Covers plain add, carry across the
  // half boundary, the largest real product, and the mod-2^PW wrap.
  task automatic test_directed_adds();
    logic [PW-1:0]   vecS [5];
    logic [PW-1:0]   vecC [5];
    logic [PW-1:0]   vecP [5];
    logic            vecM [5];
    logic [TAGW-1:0] vecT [5];
    vecS = '{22'h000400, 22'h0007FF, 22'h3FF000, 22'h3FFFFF, 22'h2AAAAA};
    vecC = '{22'h000400, 22'h000001, 22'h000001, 22'h000001, 22'h155555};
    vecP = '{22'h000800, 22'h000800, 22'h3FF001, 22'h000000, 22'h3FFFFF};
    vecM = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecT = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      s_in      = vecS[i];
      c_in      = vecC[i];
      in_tag    = vecT[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL add%0d_in_ready got %b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL add%0d_early_valid got %b want 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || prod !== vecP[i] || msb !== vecM[i] || out_tag !== vecT[i]) begin
        errors++;
        $display("[TB] FAIL add%0d_result got v=%b p=%h m=%b t=%h want v=1 p=%h m=%b t=%h",
                 i, out_valid, prod, msb, out_tag, vecP[i], vecM[i], vecT[i]);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL add%0d_extra_output got %b want 0", i, out_valid);
      end
    end
  endtask

  // Idle input buses full of X must not leak into the pipeline: no output
  // appears and the last product (3FFFFF) stays put.
  task automatic test_idle_x();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    s_in      = 'x;
    c_in      = 'x;
    in_tag    = 'x;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || prod !== 22'h3FFFFF) begin
        errors++;
        $display("[TB] FAIL idle_x%0d got v=%b p=%h want v=0 p=3fffff", i, out_valid, prod);
      end
    end
    s_in   = '0;
    c_in   = '0;
    in_tag = '0;
  endtask

  // Four tagged ops offered back to back. When the first result shows up,
  // the consumer stalls for three cycles. Each cycle the presented result
  // must equal the op at the head of the expected list, which proves both
  // stability during the stall and in-order delivery.
  task automatic test_back_to_back();
    logic [PW-1:0]   bS [4];
    logic [PW-1:0]   bC [4];
    logic [PW-1:0]   bP [4];
    logic            bM [4];
    logic [TAGW-1:0] bT [4];
    int  sent       = 0;
    int  rcv        = 0;
    int  stallLeft  = 0;
    int  stallSeen  = 0;
    int  dropAt     = -1;
    bit  firstSeen  = 1'b0;
    bS = '{22'h0007FF, 22'h012345, 22'h2AB000, 22'h0FFC00};
    bC = '{22'h000801, 22'h001111, 22'h000FFF, 22'h000400};
    bP = '{22'h001000, 22'h013456, 22'h2ABFFF, 22'h100000};
    bM = '{1'b0, 1'b0, 1'b1, 1'b0};
    bT = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
      if (out_valid === 1'b1) begin
        if (!firstSeen) begin
          firstSeen = 1'b1;
          stallLeft = 3;
        end
        checks++;
        if (prod !== bP[rcv] || msb !== bM[rcv] || out_tag !== bT[rcv]) begin
          errors++;
          $display("[TB] FAIL b2b_out%0d got p=%h m=%b t=%h want p=%h m=%b t=%h",
                   rcv, prod, msb, out_tag, bP[rcv], bM[rcv], bT[rcv]);
        end
      end
      out_ready = (stallLeft == 0);
      if (stallLeft > 0) begin
        stallLeft--;
        stallSeen++;
      end
      if (sent < 4) begin
        in_valid = 1'b1;
        s_in     = bS[sent];
        c_in     = bC[sent];
        in_tag   = bT[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready && dropAt < 0) dropAt = sent;
      if (out_valid === 1'b1 && out_ready) rcv++;
      if (in_valid && in_ready === 1'b1) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (rcv != 4) begin
      errors++;
      $display("[TB] FAIL b2b_count got %0d outputs want 4 within 40 cycles", rcv);
    end
    checks++;
    if (stallSeen != 3) begin
      errors++;
      $display("[TB] FAIL b2b_stall_cycles got %0d want 3", stallSeen);
    end
    checks++;
    if (dropAt != 2) begin
      errors++;
      $display("[TB] FAIL b2b_in_ready_drop got drop after %0d ops want 2", dropAt);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_duplicate got out_valid %b want 0", out_valid);
    end
  endtask

  // Fill both stages, hit reset mid-cycle, and expect the outputs to clear
  // before the next edge. The two flushed ops must never surface, and a
  // fresh op must take the normal two cycles.
  task automatic test_reset_midflight();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    s_in      = 22'h000111;
    c_in      = 22'h000222;
    in_tag    = 4'h5;
    @(negedge clk);
    s_in      = 22'h000333;
    c_in      = 22'h000444;
    in_tag    = 4'h6;
    @(negedge clk);
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || prod !== 22'h000333) begin
      errors++;
      $display("[TB] FAIL rstmid_prefill got v=%b p=%h want v=1 p=000333", out_valid, prod);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || prod !== '0 || msb !== 1'b0 || out_tag !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_async got v=%b p=%h m=%b t=%h want all 0", out_valid, prod, msb, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_flushed got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    in_valid = 1'b1;
    s_in     = 22'h000FFF;
    c_in     = 22'h000001;
    in_tag   = 4'h9;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_early got v=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || prod !== 22'h001000 || msb !== 1'b0 || out_tag !== 4'h9) begin
      errors++;
      $display("[TB] FAIL rstmid_next got v=%b p=%h m=%b t=%h want v=1 p=001000 m=0 t=9",
               out_valid, prod, msb, out_tag);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_ghost got v=%b want 0", out_valid);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_directed_adds();
    test_idle_x();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
